// File: rtl/controle_somador_serial_pkg.sv
// rtl/controle_somador_serial_pkg.sv - shared state encoding and default width for the serial adder
package controle_somador_serial_pkg;

  localparam int N_PADRAO = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/controle_somador_serial_if.sv
// rtl/controle_somador_serial_if.sv - request/result bundle between the board inputs and the serial adder
interface controle_somador_serial_if #(parameter int N = 4);

  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] soma;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, cin, a, b,
    input  soma, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, cin, a, b,
    output soma, cout, ovf, busy, done
  );

endinterface

// File: rtl/controle_somador_serial_celula.sv
// rtl/controle_somador_serial_celula.sv - combinational 1-bit full-adder cell shared across all bit positions
module celula_somador (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/controle_somador_serial.sv
// rtl/controle_somador_serial.sv - bit-serial add/subtract sequencer around one full-adder cell
import controle_somador_serial_pkg::*;

module controle_somador_serial #(
  parameter int N = N_PADRAO
) (
  input logic                      clk,
  input logic                      rst,
  controle_somador_serial_if.slave bus
);

  localparam int KW = $clog2(N + 1);

  estado_t         estado;
  logic [N-1:0]    sa;
  logic [N-1:0]    sb;
  logic [N-1:0]    r;
  logic            c;
  logic [KW-1:0]   k;
  logic            s_bit;
  logic            co_bit;
  logic [N-1:0]    r_next;

  celula_somador u_celula (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (c),
    .s  (s_bit),
    .co (co_bit)
  );

  assign r_next = {s_bit, r[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= IDLE;
      sa       <= '0;
      sb       <= '0;
      r        <= '0;
      c        <= 1'b0;
      k        <= '0;
      bus.soma <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.sub ? ~bus.b : bus.b;
            c        <= bus.sub | bus.cin;
            k        <= '0;
            estado   <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          r  <= r_next;
          c  <= co_bit;
          k  <= k + 1'b1;
          // On the MSB slice, c still holds the carry into the MSB, so ovf is formed here
          if (k == KW'(N - 1)) begin
            bus.soma <= r_next;
            bus.cout <= co_bit;
            bus.ovf  <= c ^ co_bit;
            bus.done <= 1'b1;
            estado   <= DONE;
          end else if (k > KW'(N - 1)) begin
            estado   <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        DONE: begin
          estado   <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          estado   <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
